// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one 4:1 datapath mux.
// Each grant carries up to MAX_BEATS beats and is followed by one idle cycle.
module mux4_rr_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BEATS  = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [3:0]            i_req,
   input  logic [3:0]            i_last,
   input  logic [DATA_WIDTH-1:0] i_data0,
   input  logic [DATA_WIDTH-1:0] i_data1,
   input  logic [DATA_WIDTH-1:0] i_data2,
   input  logic [DATA_WIDTH-1:0] i_data3,
   input  logic                  i_ready,
   output logic [3:0]            o_grant,
   output logic [1:0]            o_control,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_busy
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                state, state_nx;
   logic [3:0]            grant_nx;
   logic [1:0]            control_nx;
   logic [1:0]            ptr, ptr_nx;
   logic [3:0]            beats, beats_nx;
   logic [1:0]            pick, cand;
   logic                  found;
   logic                  xfer, done;
   logic [DATA_WIDTH-1:0] sel_data;

   // Search starts just after the last granted index; ptr itself is checked last.
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      cand  = ptr;
      for (int unsigned i = 1; i <= 4; i++) begin
         cand = ptr + 2'(i);
         if (!found && i_req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      case (o_control)
         2'd0:    sel_data = i_data0;
         2'd1:    sel_data = i_data1;
         2'd2:    sel_data = i_data2;
         default: sel_data = i_data3;
      endcase
   end

   assign o_busy  = (state == GRANT);
   assign o_valid = o_busy & i_req[o_control];
   assign o_data  = o_valid ? sel_data : '0;
   assign xfer    = o_valid & i_ready;
   assign done    = !i_req[o_control] |
                    (xfer & (i_last[o_control] | ((beats + 4'd1) == 4'(MAX_BEATS))));

   always_comb begin
      state_nx   = state;
      grant_nx   = o_grant;
      control_nx = o_control;
      ptr_nx     = ptr;
      beats_nx   = beats;
      case (state)
         IDLE: begin
            if (found) begin
               state_nx   = GRANT;
               grant_nx   = 4'b0001 << pick;
               control_nx = pick;
               ptr_nx     = pick;
               beats_nx   = '0;
            end
         end
         GRANT: begin
            if (xfer)
               beats_nx = beats + 4'd1;
            if (done) begin
               state_nx = IDLE;
               grant_nx = '0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         o_grant   <= '0;
         o_control <= '0;
         ptr       <= 2'd3;
         beats     <= '0;
      end else begin
         state     <= state_nx;
         o_grant   <= grant_nx;
         o_control <= control_nx;
         ptr       <= ptr_nx;
         beats     <= beats_nx;
      end
   end

endmodule
